// File: rtl/sha256_compress_pipe.sv
// SHA-256 compression engine: one 64-round compression per request at R rounds per clock,
// with optional midstate chaining and an internal second (double-SHA) pass over the digest.
module sha256_compress_pipe #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit DOUBLE_EN        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic         chain,
  input  logic         dbl_req,
  input  logic [511:0] block_in,
  input  logic [255:0] state_in,
  output logic [255:0] digest,
  output logic         done
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [6:0] LAST_CNT = 7'(64 - R);
  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  state_t      state_r, next_s;
  logic [6:0]  cnt_r;
  logic        dbl_pending_r;
  logic [31:0] init_r [8];
  logic [31:0] wv_r [8];
  logic [31:0] w_r [16];
  logic [31:0] w_next_s [16];
  logic [31:0] wv_next_s [8];
  logic [31:0] sum_s [8];
  logic [255:0] digest_r;
  logic        done_r;

  assign ready  = (state_r == IDLE);
  assign digest = digest_r;
  assign done   = done_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_s;
  end

  // FSM next-state decode
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (start) next_s = ROUND; else next_s = IDLE;
      ROUND:   if (cnt_r == LAST_CNT) next_s = FINAL; else next_s = ROUND;
      FINAL:   if (dbl_pending_r) next_s = ROUND; else next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // R chained rounds plus R new schedule words; the window slides by R each cycle
  always_comb begin : round_logic
    logic [31:0] ext [16+R];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    t1 = 32'h0;
    t2 = 32'h0;
    for (int i = 0; i < 16; i++) ext[i] = w_r[i];
    for (int k = 0; k < R; k++)
      ext[16+k] = ssig1(ext[14+k]) + ext[9+k] + ssig0(ext[1+k]) + ext[k];
    for (int i = 0; i < 8; i++) v[i] = wv_r[i];
    for (int j = 0; j < R; j++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[cnt_r[5:0] + 6'(j)] + ext[j];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) w_next_s[i] = ext[i+R];
    for (int i = 0; i < 8; i++) wv_next_s[i] = v[i];
  end

  // Feed-forward of the chaining value
  always_comb begin
    for (int i = 0; i < 8; i++) sum_s[i] = init_r[i] + wv_r[i];
  end

  // Datapath: capture on accept, iterate rounds, finalize or reload for the second pass
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= 7'd0;
      dbl_pending_r <= 1'b0;
      digest_r      <= 256'h0;
      done_r        <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        init_r[i] <= 32'h0;
        wv_r[i]   <= 32'h0;
      end
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r         <= 7'd0;
            dbl_pending_r <= DOUBLE_EN & dbl_req;
            for (int i = 0; i < 8; i++) begin
              init_r[i] <= chain ? state_in[255-32*i -: 32] : IV[255-32*i -: 32];
              wv_r[i]   <= chain ? state_in[255-32*i -: 32] : IV[255-32*i -: 32];
            end
            for (int i = 0; i < 16; i++) w_r[i] <= block_in[511-32*i -: 32];
          end
        end
        ROUND: begin
          cnt_r <= cnt_r + 7'(R);
          for (int i = 0; i < 16; i++) w_r[i] <= w_next_s[i];
          for (int i = 0; i < 8; i++) wv_r[i] <= wv_next_s[i];
        end
        FINAL: begin
          if (dbl_pending_r) begin
            // Second pass hashes the 32-byte first digest as one padded block from the IV
            cnt_r         <= 7'd0;
            dbl_pending_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
              w_r[i]    <= sum_s[i];
              init_r[i] <= IV[255-32*i -: 32];
              wv_r[i]   <= IV[255-32*i -: 32];
            end
            w_r[8] <= 32'h80000000;
            for (int i = 9; i < 15; i++) w_r[i] <= 32'h0;
            w_r[15] <= 32'h00000100;
          end else begin
            for (int i = 0; i < 8; i++) digest_r[255-32*i -: 32] <= sum_s[i];
            done_r <= 1'b1;
          end
        end
        default: cnt_r <= 7'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_pipe.sv
// Scoreboard bench: five engines (R=1,2,4,8 and R=8 without double hashing) share data inputs;
// stimulus pushes expected digest and done cycle, a negedge monitor pops and compares.
module tb_sha256_compress_pipe;

  localparam int NDUT = 5;
  localparam logic [511:0] ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] CH1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] CH2   = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_H1  = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] D_CH  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_DBL = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;
  localparam logic [255:0] JUNK  = {8{32'hdeadbeef}};

  typedef struct {
    int           id;
    logic [255:0] dig;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         chain;
  logic         dbl_req;
  logic [511:0] block_in;
  logic [255:0] state_in;
  logic         start_v [NDUT];
  logic         ready_v [NDUT];
  logic         done_v [NDUT];
  logic [255:0] digest_v [NDUT];
  logic         chk_idle;
  int           cyc;
  int           total;
  int           bad;
  exp_t         sb_q [$];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int RR = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
    localparam bit DD = (g == 4) ? 1'b0 : 1'b1;
    sha256_compress_pipe #(.ROUNDS_PER_CYCLE(RR), .DOUBLE_EN(DD)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .ready    (ready_v[g]),
      .chain    (chain),
      .dbl_req  (dbl_req),
      .block_in (block_in),
      .state_in (state_in),
      .digest   (digest_v[g]),
      .done     (done_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int id, input logic dbl);
    int n;
    n = 64 / ((id == 0) ? 1 : (id == 1) ? 2 : (id == 2) ? 4 : 8);
    return (dbl && id != 4) ? 2 * n + 3 : n + 2;
  endfunction

  // Monitor: match every done against the scoreboard, flag overdue entries and idle checks
  initial begin
    total = 0;
    bad   = 0;
  end
  always @(negedge clk) begin : mon
    int hit;
    for (int g = 0; g < NDUT; g++) begin
      if (done_v[g] === 1'b1) begin
        hit = -1;
        for (int k = 0; k < sb_q.size(); k++)
          if (hit < 0 && sb_q[k].id == g) hit = k;
        total++;
        if (hit < 0) begin
          bad++;
          $display("FAIL unexpected_done dut=%0d cycle=%0d got done=1 want none", g, cyc);
        end else begin
          if (digest_v[g] !== sb_q[hit].dig) begin
            bad++;
            $display("FAIL digest dut=%0d got %h want %h", g, digest_v[g], sb_q[hit].dig);
          end
          total++;
          if (cyc != sb_q[hit].cyc) begin
            bad++;
            $display("FAIL done_cycle dut=%0d got %0d want %0d", g, cyc, sb_q[hit].cyc);
          end
          sb_q.delete(hit);
        end
      end
    end
    for (int k = sb_q.size() - 1; k >= 0; k--) begin
      if (sb_q[k].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_done dut=%0d got none by %0d want done at %0d", sb_q[k].id, cyc, sb_q[k].cyc);
        sb_q.delete(k);
      end
    end
    if (chk_idle) begin
      for (int g = 0; g < NDUT; g++) begin
        total += 3;
        if (ready_v[g] !== 1'b1) begin
          bad++;
          $display("FAIL idle_ready dut=%0d got %b want 1", g, ready_v[g]);
        end
        if (done_v[g] !== 1'b0) begin
          bad++;
          $display("FAIL idle_done dut=%0d got %b want 0", g, done_v[g]);
        end
        if (digest_v[g] !== 256'h0) begin
          bad++;
          $display("FAIL idle_digest dut=%0d got %h want 0", g, digest_v[g]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic job(input int id, input logic [511:0] blk, input logic [255:0] st,
                     input logic ch, input logic dbl, input logic [255:0] expd);
    int n;
    n = 0;
    tick();
    while (ready_v[id] !== 1'b1) begin
      n++;
      if (n > 400) begin
        $display("FAIL ready_timeout dut=%0d got ready=0 want 1", id);
        $fatal(1, "engine never became ready");
      end
      tick();
    end
    block_in    = blk;
    state_in    = st;
    chain       = ch;
    dbl_req     = dbl;
    start_v[id] = 1'b1;
    sb_q.push_back('{id, expd, cyc + lat(id, dbl)});
    tick();
    start_v[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      $display("FAIL drain_timeout got %0d pending want 0", sb_q.size());
      $fatal(1, "scoreboard did not drain");
    end
  endtask

  initial begin
    int t0;
    int acc;
    int guard;
    rst      = 1'b1;
    chain    = 1'b0;
    dbl_req  = 1'b0;
    block_in = ABC;
    state_in = JUNK;
    chk_idle = 1'b0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b1;

    // Reset held three cycles with start asserted: engines must stay idle
    tick();
    chk_idle = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
    repeat (2) tick();
    chk_idle = 1'b0;

    for (int g = 0; g < NDUT; g++) job(g, ABC, JUNK, 1'b0, 1'b0, D_ABC);
    drain();
    for (int g = 0; g < NDUT; g++) job(g, ABC, JUNK, 1'b0, 1'b1, (g == 4) ? D_ABC : D_DBL);
    drain();
    job(0, EMPTY, JUNK, 1'b0, 1'b0, D_EMP);
    job(3, EMPTY, JUNK, 1'b0, 1'b0, D_EMP);
    job(0, CH1, JUNK, 1'b0, 1'b0, D_H1);
    job(3, CH1, JUNK, 1'b0, 1'b0, D_H1);
    job(0, CH2, D_H1, 1'b1, 1'b0, D_CH);
    job(3, CH2, D_H1, 1'b1, 1'b0, D_CH);
    drain();

    // Abort in ROUND cycle 20, then restart immediately after the reset edge
    tick();
    block_in   = ABC;
    chain      = 1'b0;
    dbl_req    = 1'b0;
    start_v[0] = 1'b1;
    t0         = cyc;
    tick();
    start_v[0] = 1'b0;
    while (cyc < t0 + 20) tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    chk_idle   = 1'b1;
    start_v[0] = 1'b1;
    sb_q.push_back('{0, D_ABC, cyc + lat(0, 1'b0)});
    tick();
    chk_idle   = 1'b0;
    start_v[0] = 1'b0;
    drain();

    // start held every cycle: busy starts ignored, start in the done cycle accepted
    block_in = ABC;
    acc      = 0;
    guard    = 0;
    while (acc < 2 && guard < 400) begin
      tick();
      start_v[0] = 1'b1;
      if (acc == 1) block_in = EMPTY;
      if (ready_v[0] === 1'b1) begin
        sb_q.push_back('{0, (acc == 0) ? D_ABC : D_EMP, cyc + lat(0, 1'b0)});
        acc++;
      end
      guard++;
    end
    tick();
    start_v[0] = 1'b0;
    if (acc < 2) begin
      $display("FAIL b2b_accept got %0d accepts want 2", acc);
      $fatal(1, "back-to-back start not accepted");
    end
    drain();
    repeat (80) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
